adder_share_ctrl: RTL and testbench
===================================

# adder_share_ctrl

Sequencing and arbitration controller for the shared 4-bit `simple_adder` slice. Two requesters each submit a wide add, `4*WORD_NIBBLES` bits plus carry-in. The block arbitrates round-robin between them, then drives the single external slice one nibble per cycle, LSB first, chaining the carry through a register. It sits between requester logic and the `simple_adder` instance and returns one registered result per accepted request.

## Interface
- `WORD_NIBBLES`, 4, operand width in nibbles (≥1); operand width `W = 4*WORD_NIBBLES`
- `clk  in  1  clock; all logic on rising edge`
- `rst  in  1  reset; synchronous, active-high`
- `req0_valid  in  1  requester 0 has an operation`
- `req0_ready  out  1  requester 0 accepted this cycle`
- `req0_a, req0_b  in  W  requester 0 operands`
- `req0_cin  in  1  requester 0 carry-in`
- `req1_valid, req1_ready, req1_a, req1_b, req1_cin`: same as requester 0, for requester 1
- `add_a, add_b  out  4  nibble operands to the slice`
- `add_cin  out  1  carry to the slice`
- `add_sum  in  4  slice sum (combinational from `add_*`)`
- `add_cout  in  1  slice carry-out`
- `rsp_valid  out  1  result available`
- `rsp_ready  in  1  consumer takes result`
- `rsp_id  out  1  requester that owns the result`
- `rsp_sum  out  W  wide sum`
- `rsp_cout  out  1  final carry-out`

## Operation
- FSM states: IDLE, RUN, RESP.
- **IDLE**
  - Grant is round-robin over the asserted valids. With both valid, grant goes to the requester not granted last.
  - `reqk_ready` is 1 only for the granted requester, and only in IDLE.
  - On `valid && ready`:
    - latch a, b and cin into operand registers
    - latch the id into `rsp_id`
    - clear the nibble index
    - update the last-grant pointer
    - go to RUN
- **RUN**
  - `add_a`/`add_b` = nibble[idx] of the latched operands.
  - `add_cin` = latched cin when idx=0, otherwise the carry register.
  - Each cycle: write `add_sum` into `rsp_sum[4*idx+:4]`, load `add_cout` into the carry register, increment idx.
  - At idx=`WORD_NIBBLES-1`: write the last nibble, set `rsp_cout` = `add_cout`, go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_sum`, `rsp_cout` and `rsp_id` are held stable.
  - On `rsp_ready`, go to IDLE.
- Outside RUN, `add_a`/`add_b`/`add_cin` are driven 0.
- Arithmetic: `{rsp_cout, rsp_sum} = a + b + cin` modulo `2^(W+1)`. Result is exact with no saturation; all-ones + all-ones + 1 gives cout=1 and sum = all-ones.
- Requesters not granted must hold their valid and data stable; requester-side drop is not supported.

## Timing
- Reset values:
  - `req0_ready`=`req1_ready`=0
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0
  - `add_*`=0
  - state=IDLE
  - last-grant pointer=1, so requester 0 wins the first tie
- Cycle counting: accept in cycle T; nibble i is computed in cycle T+1+i; `rsp_valid` rises in cycle T+1+`WORD_NIBBLES` (T+5 for the default).
- Minimum spacing between accepts is `WORD_NIBBLES+2` cycles, when `rsp_ready` is held 1.
- `reqk_ready` is 0 throughout RUN and RESP. A new request is never accepted in the same cycle a response is taken; IDLE always lasts at least one cycle.
- `rst` asserted in any state:
  - the next state is IDLE with the reset values above
  - an in-flight operation is discarded and no response is produced
  - the slice carry chain is not preserved

## Configuration
- `ADDER_CTRL_OVF_EN` defined:
  - adds output port `rsp_ovf` (out, 1): two's-complement signed overflow = (a[W-1]==b[W-1]) && (rsp_sum[W-1]!=a[W-1]), computed on the latched operands.
  - `rsp_ovf` is registered with `rsp_sum`, held through RESP, and resets to 0.
- Undefined: the port is absent and no overflow logic is built. All other behaviour is identical.

## Test plan
- **Carry wrap:** after reset, req0 with a=0xFFFF, b=0x0001, cin=0 → `rsp_valid` 5 cycles after accept with sum=0x0000, cout=1, id=0. With `ADDER_CTRL_OVF_EN`, ovf=0.
- **Cin propagation:** req1 with a=0x00FF, b=0x0000, cin=1 → sum=0x0100, cout=0, id=1. Per-cycle slice inputs observed as a-nibbles F,F,0,0 and cin 1,1,1,0.
- **Tie arbitration:** both valid from reset with a=0x1234, b=0x1111 and a=0x8000, b=0x8000 → req0 served first (0x2345, cout 0), then req1 (0x0000, cout 1). A following tie grants req0.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_valid`/`rsp_sum` stable, both readies 0. Release → IDLE next cycle, new accept one cycle later.
- **Reset mid-RUN:** pulse `rst` at nibble 2 → no `rsp_valid`, outputs at reset values. The next request completes correctly with req0 preferred.
- **Overflow, with macro:** a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, ovf=1, cout=0.

Source files
------------

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer that time-shares one 4-bit adder slice between two wide-add requesters.
// Optional signed-overflow output `rsp_ovf` is built when ADDER_CTRL_OVF_EN is defined.
module adder_share_ctrl #(
  parameter int unsigned WORD_NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [4*WORD_NIBBLES-1:0] req0_a,
  input  logic [4*WORD_NIBBLES-1:0] req0_b,
  input  logic                      req0_cin,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [4*WORD_NIBBLES-1:0] req1_a,
  input  logic [4*WORD_NIBBLES-1:0] req1_b,
  input  logic                      req1_cin,
  output logic [3:0]                add_a,
  output logic [3:0]                add_b,
  output logic                      add_cin,
  input  logic [3:0]                add_sum,
  input  logic                      add_cout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [4*WORD_NIBBLES-1:0] rsp_sum,
  output logic                      rsp_cout
`ifdef ADDER_CTRL_OVF_EN
  ,
  output logic                      rsp_ovf
`endif
);

  localparam int unsigned W     = 4 * WORD_NIBBLES;
  localparam int unsigned IDX_W = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             last_nibble;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             op_cin;
  logic             carry;
  logic [IDX_W-1:0] idx;

  // Round-robin: on a tie the requester not served last wins
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready  = (state == IDLE) && req0_valid && !grant;
  assign req1_ready  = (state == IDLE) && req1_valid && grant;
  assign accept      = req0_ready | req1_ready;
  assign last_nibble = (idx == IDX_W'(WORD_NIBBLES - 1));
  assign rsp_valid   = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_nibble) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice operands: current nibble of the latched operands, quiet outside RUN
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = 4'(op_a >> {idx, 2'b00});
      add_b   = 4'(op_b >> {idx, 2'b00});
      add_cin = (idx == '0) ? op_cin : carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      carry      <= 1'b0;
      idx        <= '0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
`ifdef ADDER_CTRL_OVF_EN
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_a       <= grant ? req1_a : req0_a;
        op_b       <= grant ? req1_b : req0_b;
        op_cin     <= grant ? req1_cin : req0_cin;
        rsp_id     <= grant;
        idx        <= '0;
        last_grant <= grant;
      end
      if (state == RUN) begin
        for (int i = 0; i < int'(WORD_NIBBLES); i++) begin
          if (idx == IDX_W'(i)) rsp_sum[4*i +: 4] <= add_sum;
        end
        carry <= add_cout;
        idx   <= idx + IDX_W'(1);
        if (last_nibble) begin
          rsp_cout <= add_cout;
`ifdef ADDER_CTRL_OVF_EN
          // Top bit of the final nibble is the sign of the wide sum
          rsp_ovf  <= (op_a[W-1] == op_b[W-1]) && (add_sum[3] != op_a[W-1]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a behavioural 4-bit slice and a queue-based response scoreboard.
module tb_adder_share_ctrl;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [15:0] rsp_sum;
`ifdef ADDER_CTRL_OVF_EN
  logic        rsp_ovf;
`endif

  typedef struct packed {
    logic        id;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  adder_share_ctrl #(.WORD_NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ADDER_CTRL_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  // Behavioural simple_adder slice
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: pops one expected entry per completed response handshake
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d sum=0x%0h, expected no response", rsp_id, rsp_sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
`ifdef ADDER_CTRL_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input bit k, input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input bit expect_it, input logic [15:0] es, input logic ec, input logic eo);
    bit acc;
    if (k) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      if (k ? req1_ready : req0_ready) begin
        acc = 1'b1;
        if (expect_it) q.push_back('{id: k, sum: es, cout: ec, ovf: eo});
      end
    end
    if (!acc) note_fail("accept_timeout");
    @(posedge clk);
    #1;
    if (k) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic serve_both(input logic [15:0] a0, input logic [15:0] b0, input logic c0,
                            input logic [15:0] a1, input logic [15:0] b1, input logic c1);
    bit d0, d1;
    req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_a = a1; req1_b = b1; req1_cin = c1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 60 && (req0_valid || req1_valid); c++) begin
      @(negedge clk);
      d0 = req0_valid && req0_ready;
      d1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (d0) req0_valid = 1'b0;
      if (d1) req1_valid = 1'b0;
    end
    if (req0_valid || req1_valid) begin
      note_fail("tie_accept_timeout");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100 && q.size() != 0; c++) @(posedge clk);
    if (q.size() != 0) begin
      note_fail("drain_timeout");
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_nib [4];
    logic       exp_cin [4];
    bit         seen;

    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_ready0", 32'(req0_ready), 32'd0);
    check("reset_ready1", 32'(req1_ready), 32'd0);
    check("reset_add", {add_a, add_b, 23'd0, add_cin}, 32'd0);
    check("reset_rsp", {rsp_sum, 14'd0, rsp_id, rsp_cout}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Carry wrap with latency check
    send(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("latency_c%0d", i), 32'(rsp_valid), (i == 5) ? 32'd1 : 32'd0);
    end
    wait_drain();

    // Cin propagation with per-cycle slice inputs
    exp_nib = '{4'hF, 4'hF, 4'h0, 4'h0};
    exp_cin = '{1'b1, 1'b1, 1'b1, 1'b0};
    send(1'b1, 16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("slice_a_n%0d", i), 32'(add_a), 32'(exp_nib[i]));
      check($sformatf("slice_cin_n%0d", i), 32'(add_cin), 32'(exp_cin[i]));
    end
    wait_drain();

    // Tie from reset: req0 first, then req1; a following tie goes to req0 again
    do_reset();
    q.push_back('{id: 1'b0, sum: 16'h2345, cout: 1'b0, ovf: 1'b0});
    q.push_back('{id: 1'b1, sum: 16'h0000, cout: 1'b1, ovf: 1'b1});
    serve_both(16'h1234, 16'h1111, 1'b0, 16'h8000, 16'h8000, 1'b0);
    wait_drain();
    q.push_back('{id: 1'b0, sum: 16'h0003, cout: 1'b0, ovf: 1'b0});
    q.push_back('{id: 1'b1, sum: 16'h2000, cout: 1'b0, ovf: 1'b0});
    serve_both(16'h0001, 16'h0002, 1'b0, 16'h1000, 16'h0FFF, 1'b1);
    wait_drain();

    // Backpressure in RESP with a pending req1
    rsp_ready = 1'b0;
    send(1'b0, 16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);
    req1_a = 16'h0F0F; req1_b = 16'h00F1; req1_cin = 1'b0; req1_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) note_fail("bp_rsp_timeout");
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_sum", 32'(rsp_sum), 32'h0007);
      check("bp_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_idle_ready1", 32'(req1_ready), 32'd1);
    if (req1_ready) q.push_back('{id: 1'b1, sum: 16'h1000, cout: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_drain();

    // Reset at nibble 2 discards the operation; next tie prefers req0
    send(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_add", {add_a, add_b, 23'd0, add_cin}, 32'd0);
    check("mid_rst_rsp", {rsp_sum, 14'd0, rsp_id, rsp_cout}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    q.push_back('{id: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
    q.push_back('{id: 1'b1, sum: 16'hFFFF, cout: 1'b1, ovf: 1'b0});
    serve_both(16'h4000, 16'h4000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_drain();

    // Signed overflow case
    send(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
